// File: rtl/ms_timestamp_gen_if.sv
// Snapshot handshake between the timestamp generator (slave) and its consumer (master).
interface ms_timestamp_gen_if;
  logic        SNAP_REQ;
  logic        SNAP_ACK;
  logic        SNAP_VALID;
  logic [31:0] SNAP_TIME;
  logic        SNAP_OVR;

  modport master (
    output SNAP_REQ, SNAP_ACK,
    input  SNAP_VALID, SNAP_TIME, SNAP_OVR
  );

  modport slave (
    input  SNAP_REQ, SNAP_ACK,
    output SNAP_VALID, SNAP_TIME, SNAP_OVR
  );
endinterface

// File: rtl/ms_timestamp_gen.sv
// Millisecond timebase with 1 kHz tick and a held-snapshot handshake.
// Optional TIMESTAMP_PRESET_EN adds LOAD_STB/LOAD_VAL to preset the ms counter.
module ms_timestamp_gen #(
  parameter int unsigned CYCLES_PER_MS = 1000
) (
  input  logic              CLK_1MHZ_IN,
  input  logic              RESET,
`ifdef TIMESTAMP_PRESET_EN
  input  logic              LOAD_STB,
  input  logic [31:0]       LOAD_VAL,
`endif
  output logic              TICK_1KHZ_OUT,
  output logic [31:0]       TIME_MS_OUT,
  ms_timestamp_gen_if.slave snap
);

  localparam logic [16:0] PRESC_MAX = 17'(CYCLES_PER_MS - 1);

  typedef enum logic {IDLE, HOLD} snap_state_t;

  logic [16:0]  presc;
  logic [31:0]  time_ms;
  logic         tick;
  snap_state_t  state;
  logic         snap_vld;
  logic [31:0]  snap_ts;
  logic         snap_ovr;
  logic         drop;

  always_ff @(posedge CLK_1MHZ_IN) begin
    if (!RESET) begin
      presc   <= '0;
      time_ms <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (presc == PRESC_MAX) begin
        presc   <= '0;
        time_ms <= time_ms + 32'd1;
        tick    <= 1'b1;
      end else begin
        presc <= presc + 17'd1;
      end
`ifdef TIMESTAMP_PRESET_EN
      // Preset wins over a coincident rollover and swallows its tick.
      if (LOAD_STB) begin
        presc   <= '0;
        time_ms <= LOAD_VAL;
        tick    <= 1'b0;
      end
`endif
    end
  end

  // Capture reads the pre-edge time, so a request on a rollover/load edge sees the old value.
  always_ff @(posedge CLK_1MHZ_IN) begin
    if (!RESET) begin
      state    <= IDLE;
      snap_vld <= 1'b0;
      snap_ts  <= '0;
      snap_ovr <= 1'b0;
      drop     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap.SNAP_REQ) begin
            snap_ts  <= time_ms;
            snap_ovr <= drop;
            drop     <= 1'b0;
            snap_vld <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (snap.SNAP_REQ) drop <= 1'b1;
          if (snap.SNAP_ACK) begin
            snap_vld <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign TICK_1KHZ_OUT   = tick;
  assign TIME_MS_OUT     = time_ms;
  assign snap.SNAP_VALID = snap_vld;
  assign snap.SNAP_TIME  = snap_ts;
  assign snap.SNAP_OVR   = snap_ovr;

endmodule

// File: tb/tb_ms_timestamp_gen.sv
// Self-checking bench for ms_timestamp_gen: arithmetic timebase model plus snapshot scoreboard.
module tb_ms_timestamp_gen;
  localparam int unsigned CPM = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [31:0] tms;
  logic        load;
  logic [31:0] lval;

  ms_timestamp_gen_if snap_if ();

  always #5 clk = ~clk;

  ms_timestamp_gen #(.CYCLES_PER_MS(CPM)) dut (
    .CLK_1MHZ_IN   (clk),
    .RESET         (rst),
`ifdef TIMESTAMP_PRESET_EN
    .LOAD_STB      (load),
    .LOAD_VAL      (lval),
`endif
    .TICK_1KHZ_OUT (tick),
    .TIME_MS_OUT   (tms),
    .snap          (snap_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: time = base + elapsed/CPM, elapsed counted from the last reset or load.
  int unsigned m_n;
  logic [31:0] m_base;
  logic        m_tick;
  logic        m_held, m_ovr, m_drop;
  logic [31:0] m_stime;

  function automatic logic [31:0] m_time();
    return m_base + 32'(m_n / CPM);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    logic [31:0] pre;
    pre = m_time();
    @(posedge clk);
    if (!rst) begin
      m_n = 0; m_base = '0; m_tick = 1'b0;
      m_held = 1'b0; m_stime = '0; m_ovr = 1'b0; m_drop = 1'b0;
    end else begin
      if (!m_held) begin
        if (snap_if.SNAP_REQ) begin
          m_held = 1'b1; m_stime = pre; m_ovr = m_drop; m_drop = 1'b0;
        end
      end else begin
        if (snap_if.SNAP_REQ) m_drop = 1'b1;
        if (snap_if.SNAP_ACK) m_held = 1'b0;
      end
`ifdef TIMESTAMP_PRESET_EN
      if (load) begin
        m_n = 0; m_base = lval; m_tick = 1'b0;
      end else
`endif
      begin
        m_n++;
        m_tick = (m_n % CPM == 0);
      end
    end
    #1;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("time_ms", tms, m_time());
    chk("snap_valid", 32'(snap_if.SNAP_VALID), 32'(m_held));
    chk("snap_time", snap_if.SNAP_TIME, m_stime);
    chk("snap_ovr", 32'(snap_if.SNAP_OVR), 32'(m_ovr));
  endtask

  typedef struct {
    logic req;
    logic ack;
    logic exp_vld;
    logic exp_ovr;
  } vec_t;

  vec_t tbl[14];
  int   ticks[$];
  int   cnt;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; load = 1'b0; lval = '0;
    snap_if.SNAP_REQ = 1'b0; snap_if.SNAP_ACK = 1'b0;
    m_n = 0; m_base = '0; m_tick = 1'b0;
    m_held = 1'b0; m_stime = '0; m_ovr = 1'b0; m_drop = 1'b0;

    // Reset with other inputs active must still clear everything.
    snap_if.SNAP_REQ = 1'b1;
    repeat (4) cyc();
    snap_if.SNAP_REQ = 1'b0;
    chk("rst_time", tms, 32'd0);
    chk("rst_valid", 32'(snap_if.SNAP_VALID), 32'd0);

    // Three ticks at exactly 1000/2000/3000 cycles after release.
    rst = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      cyc();
      if (tick) ticks.push_back(i);
    end
    chk("tick_count", 32'(ticks.size()), 32'd3);
    for (int i = 0; i < ticks.size() && i < 3; i++)
      chk("tick_pos", 32'(ticks[i]), 32'((i + 1) * 1000));
    chk("time_3000", tms, 32'd3);

    // Request on the 5->6 rollover edge captures 5.
    repeat (2999) cyc();
    snap_if.SNAP_REQ = 1'b1;
    cyc();
    snap_if.SNAP_REQ = 1'b0;
    chk("edge_snap_time", snap_if.SNAP_TIME, 32'd5);
    chk("edge_snap_valid", 32'(snap_if.SNAP_VALID), 32'd1);
    chk("edge_time", tms, 32'd6);
    snap_if.SNAP_ACK = 1'b1;
    cyc();
    snap_if.SNAP_ACK = 1'b0;

    // Handshake / overrun sequence.
    for (int i = 0; i < 14; i++) begin
      snap_if.SNAP_REQ = tbl[i].req;
      snap_if.SNAP_ACK = tbl[i].ack;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 32'(snap_if.SNAP_VALID), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_ovr", i), 32'(snap_if.SNAP_OVR), 32'(tbl[i].exp_ovr));
    end
    snap_if.SNAP_REQ = 1'b0; snap_if.SNAP_ACK = 1'b0;

    // Random handshake traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      snap_if.SNAP_REQ = ($urandom_range(0, 3) == 0);
      snap_if.SNAP_ACK = ($urandom_range(0, 2) == 0);
      cyc();
    end
    snap_if.SNAP_REQ = 1'b0; snap_if.SNAP_ACK = 1'b1;
    cyc();
    snap_if.SNAP_ACK = 1'b0;

    // Reset mid-HOLD at 42 ms.
    cnt = 0;
    while (m_time() != 32'd42 && cnt < 50000) begin cyc(); cnt++; end
    chk("reach_42_timeout", 32'(cnt < 50000), 32'd1);
    snap_if.SNAP_REQ = 1'b1;
    cyc();
    snap_if.SNAP_REQ = 1'b0;
    cyc();
    chk("hold_valid", 32'(snap_if.SNAP_VALID), 32'd1);
    chk("hold_time", snap_if.SNAP_TIME, 32'd42);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("midhold_rst_valid", 32'(snap_if.SNAP_VALID), 32'd0);
    chk("midhold_rst_time", tms, 32'd0);
    cnt = 0;
    do begin cyc(); cnt++; end while (!tick && cnt < 2000);
    chk("tick_after_rst", 32'(cnt), 32'd1000);

`ifdef TIMESTAMP_PRESET_EN
    // Load on a rollover edge with a coincident request.
    while (m_n % CPM != CPM - 1) cyc();
    cnt = int'(m_time());
    load = 1'b1; lval = 32'd100; snap_if.SNAP_REQ = 1'b1;
    cyc();
    load = 1'b0; snap_if.SNAP_REQ = 1'b0;
    chk("load_time", tms, 32'd100);
    chk("load_tick", 32'(tick), 32'd0);
    chk("load_snap_time", snap_if.SNAP_TIME, 32'(cnt));
    snap_if.SNAP_ACK = 1'b1;
    cnt = 0;
    do begin cyc(); snap_if.SNAP_ACK = 1'b0; cnt++; end while (!tick && cnt < 2000);
    chk("load_next_tick", 32'(cnt), 32'd1000);
    chk("load_next_time", tms, 32'd101);

    // Wrap from 0xFFFFFFFF to 0.
    load = 1'b1; lval = 32'hFFFF_FFFE;
    cyc();
    load = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      cyc();
      if (i == 1000) begin
        chk("wrap_tick1", 32'(tick), 32'd1);
        chk("wrap_time1", tms, 32'hFFFF_FFFF);
      end
      if (i == 2000) begin
        chk("wrap_tick2", 32'(tick), 32'd1);
        chk("wrap_time2", tms, 32'h0000_0000);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
